// File: rtl/load_store_unit.sv
// Memory-stage load/store unit for the pipelined RV32I core.
// Turns load/store instructions in EX/MEM into a single-outstanding
// request/acknowledge data-memory access with byte strobes, stalls the
// pipeline while the access is in flight, and returns aligned,
// sign- or zero-extended load data to writeback.
module load_store_unit #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [4:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        lsu_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_exc,
  output logic        bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Last REQ cycle index before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  ack_cnt;
  logic [2:0]  acc_func3;
  logic [1:0]  acc_off;
  logic [4:0]  acc_rd;

  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        func3_legal;
  logic        aligned;
  logic        accept;
  logic        reject;
  logic [1:0]  off;
  logic [3:0]  wstrb_next;
  logic [31:0] wdata_next;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Decode the EX/MEM instruction: memory-op detection, legality and alignment.
  always_comb begin
    off      = alu_out[1:0];
    is_load  = (opcode == 5'b00000);
    is_store = (opcode == 5'b01000);
    mem_op   = ex_valid & (is_load | is_store);
    case (func3)
      3'b000, 3'b001, 3'b010: func3_legal = 1'b1;
      3'b100, 3'b101:         func3_legal = is_load;
      default:                func3_legal = 1'b0;
    endcase
    case (func3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
    accept = mem_op & func3_legal & aligned;
    reject = mem_op & ~accept;
  end

  // Build byte strobes and lane-replicated write data for the accepted store.
  always_comb begin
    wstrb_next = 4'b0000;
    wdata_next = 32'h0000_0000;
    if (is_store) begin
      case (func3[1:0])
        2'b00: begin
          wstrb_next = 4'b0001 << off;
          wdata_next = {4{store_data[7:0]}};
        end
        2'b01: begin
          wstrb_next = 4'b0011 << off;
          wdata_next = {2{store_data[15:0]}};
        end
        default: begin
          wstrb_next = 4'b1111;
          wdata_next = store_data;
        end
      endcase
    end else begin
      wstrb_next = 4'b0000;
      wdata_next = 32'h0000_0000;
    end
  end

  // Select the addressed byte/halfword of the read word and extend it.
  always_comb begin
    case (acc_off)
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    if (acc_off[1]) begin
      ld_half = dmem_rdata[31:16];
    end else begin
      ld_half = dmem_rdata[15:0];
    end
    case (acc_func3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h00_0000, ld_byte};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // Stall while accepting an op or while its request is outstanding; reset forces it low.
  assign lsu_stall = rst_n & (((state == IDLE) & accept) | (state == REQ));

  // Access FSM: IDLE accepts, REQ waits for ack or timeout, DONE reports for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_cnt    <= 8'd0;
      acc_func3  <= 3'b000;
      acc_off    <= 2'b00;
      acc_rd     <= 5'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_wstrb <= 4'b0000;
      dmem_wdata <= 32'h0000_0000;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'h0000_0000;
      lsu_exc    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      lsu_exc  <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {alu_out[31:2], 2'b00};
            dmem_wstrb <= wstrb_next;
            dmem_wdata <= wdata_next;
            acc_func3  <= func3;
            acc_off    <= off;
            acc_rd     <= rd;
            ack_cnt    <= 8'd0;
            state      <= REQ;
          end else if (reject) begin
            lsu_exc <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            // An ack in the timeout cycle still completes normally.
            dmem_req <= 1'b0;
            state    <= DONE;
            if (!dmem_we) begin
              wb_valid <= 1'b1;
              wb_rd    <= acc_rd;
              wb_data  <= ld_ext;
            end else begin
              wb_valid <= 1'b0;
            end
          end else if (ack_cnt == CNT_LAST) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            state    <= DONE;
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          dmem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed memory ops against a
// transaction-level model of the expected memory port and writeback behaviour.
module tb_load_store_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] alu_out = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd = 5'd0;
  logic        lsu_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_exc;
  logic        bus_err;

  load_store_unit #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .opcode(opcode),
    .func3(func3), .alu_out(alu_out), .store_data(store_data), .rd(rd),
    .lsu_stall(lsu_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .lsu_exc(lsu_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  // Expected outputs for the current cycle, maintained by the stimulus tasks.
  logic        exp_stall = 1'b0;
  logic        exp_req = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [3:0]  exp_strb = 4'h0;
  logic [31:0] exp_wdata = 32'h0;
  logic        exp_valid = 1'b0;
  logic [4:0]  exp_rd = 5'd0;
  logic [31:0] exp_data = 32'h0;
  logic        exp_exc = 1'b0;
  logic        exp_berr = 1'b0;

  int          sc, rc;
  logic [3:0]  ss;
  logic [31:0] sw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic m_legal(input logic st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int m_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_aligned(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % m_bytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((1 << m_bytes(f3)) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_bytes(f3) == 1) return 32'(d[7:0]) * 32'h0101_0101;
    if (m_bytes(f3) == 2) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * int'(a[1:0]));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      chk("wb_valid", 32'(wb_valid), 32'(exp_valid));
      chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
      chk("wb_data", wb_data, exp_data);
      chk("lsu_exc", 32'(lsu_exc), 32'(exp_exc));
      chk("bus_err", 32'(bus_err), 32'(exp_berr));
      if (exp_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_strb));
        if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One memory op: ack_at = REQ cycle index of the ack, -1 for no ack.
  task automatic mem_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdv, input int ack_at,
                        input logic [4:0] rdx, output int stall_cyc, output int req_cyc,
                        output logic [3:0] seen_strb, output logic [31:0] seen_wdata);
    logic acked;
    stall_cyc = 0;
    req_cyc = 0;
    seen_strb = 4'h0;
    seen_wdata = 32'h0;
    acked = 1'b0;
    ex_valid = 1'b1;
    opcode = st ? 5'b01000 : 5'b00000;
    func3 = f3;
    alu_out = a;
    store_data = sd;
    rd = rdx;
    dmem_ack = 1'b0;
    exp_valid = 1'b0;
    exp_exc = 1'b0;
    exp_berr = 1'b0;
    exp_req = 1'b0;
    if (!(m_legal(st, f3) && m_aligned(f3, a))) begin
      exp_stall = 1'b0;
      #2;
      if (lsu_stall) stall_cyc++;
      step();
      ex_valid = 1'b0;
      exp_exc = 1'b1;
      step();
      exp_exc = 1'b0;
      return;
    end
    exp_stall = 1'b1;
    #2;
    if (lsu_stall) stall_cyc++;
    step();
    ex_valid = 1'b0;
    exp_req = 1'b1;
    exp_we = st;
    exp_addr = {a[31:2], 2'b00};
    exp_strb = st ? m_strb(f3, a) : 4'b0000;
    exp_wdata = m_wdata(f3, sd);
    for (int k = 0; k < T; k++) begin
      dmem_ack = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rdv : 32'h0BAD_0BAD;
      #2;
      if (lsu_stall) stall_cyc++;
      if (dmem_req) req_cyc++;
      seen_strb = dmem_wstrb;
      seen_wdata = dmem_wdata;
      step();
      if (k == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    dmem_ack = 1'b0;
    exp_req = 1'b0;
    exp_stall = 1'b0;
    if (acked && !st) begin
      exp_valid = 1'b1;
      exp_rd = rdx;
      exp_data = m_load(f3, a, rdv);
    end
    if (!acked) exp_berr = 1'b1;
    #2;
    if (lsu_stall) stall_cyc++;
    step();
    exp_valid = 1'b0;
    exp_berr = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1);
  end

  initial begin
    // Reset: all registered outputs low, even with an ack on the port.
    dmem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    step();
    step();
    dmem_ack = 1'b0;
    rst_n = 1'b1;
    step();

    // Non-memory op and ex_valid=0 with a load opcode: no stall, no request.
    ex_valid = 1'b1; opcode = 5'b01100; func3 = 3'd2;
    step();
    ex_valid = 1'b0; opcode = 5'b00000;
    step();

    // lw, ack two cycles after req.
    mem_op(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 2, 5'd7, sc, rc, ss, sw);
    chk("lw_stall_cycles", 32'(sc), 32'd4);
    chk("lw_req_cycles", 32'(rc), 32'd3);
    chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("lw_wb_rd", 32'(wb_rd), 32'd7);

    // Sub-word loads of 0x80FF7F01, minimum latency, back to back.
    mem_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0, 5'd1, sc, rc, ss, sw);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(sc), 32'd2);
    mem_op(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0, 5'd2, sc, rc, ss, sw);
    chk("lbu_data", wb_data, 32'h0000_0080);
    mem_op(1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 0, 5'd3, sc, rc, ss, sw);
    chk("lh_data", wb_data, 32'hFFFF_80FF);
    mem_op(1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 0, 5'd4, sc, rc, ss, sw);
    chk("lhu_data", wb_data, 32'h0000_80FF);
    mem_op(1'b0, 3'b000, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 1, 5'd5, sc, rc, ss, sw);
    chk("lb_off1_data", wb_data, 32'h0000_007F);

    // Stores: strobes and replicated data, no writeback.
    mem_op(1'b1, 3'b000, 32'h0000_2001, 32'h1234_5678, 32'h0, 1, 5'd9, sc, rc, ss, sw);
    chk("sb_wstrb", 32'(ss), 32'h2);
    chk("sb_wdata", sw, 32'h7878_7878);
    mem_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0, 0, 5'd9, sc, rc, ss, sw);
    chk("sh_wstrb", 32'(ss), 32'hC);
    chk("sh_wdata", sw, 32'h5678_5678);
    mem_op(1'b1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 3, 5'd9, sc, rc, ss, sw);
    chk("sw_wstrb", 32'(ss), 32'hF);
    chk("store_wb_data_held", wb_data, 32'h0000_007F);

    // Misaligned and unsupported ops: exception pulse, no stall, no request.
    mem_op(1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0, 5'd6, sc, rc, ss, sw);
    chk("lw_misaligned_stall", 32'(sc), 32'd0);
    mem_op(1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0, 5'd6, sc, rc, ss, sw);
    chk("ld_f3_011_stall", 32'(sc), 32'd0);
    mem_op(1'b0, 3'b101, 32'h0000_1001, 32'h0, 32'h0, 0, 5'd6, sc, rc, ss, sw);
    mem_op(1'b1, 3'b100, 32'h0000_2000, 32'h0, 32'h0, 0, 5'd6, sc, rc, ss, sw);

    // Timeout: no ack, then ack in the final REQ cycle.
    mem_op(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h0, -1, 5'd10, sc, rc, ss, sw);
    chk("timeout_req_cycles", 32'(rc), 32'(T));
    chk("timeout_wb_data_held", wb_data, 32'h0000_007F);
    chk("timeout_wb_rd_held", 32'(wb_rd), 32'd5);
    mem_op(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h0123_4567, T - 1, 5'd11, sc, rc, ss, sw);
    chk("late_ack_req_cycles", 32'(rc), 32'(T));
    chk("late_ack_wb_data", wb_data, 32'h0123_4567);
    chk("late_ack_wb_rd", 32'(wb_rd), 32'd11);

    // Reset while in REQ: request and stall drop at once, later ack ignored.
    cmp_en = 1'b0;
    ex_valid = 1'b1; opcode = 5'b00000; func3 = 3'b010; alu_out = 32'h0000_4000; rd = 5'd3;
    step();
    ex_valid = 1'b0;
    #2;
    chk("rst_pre_req", 32'(dmem_req), 32'd1);
    chk("rst_pre_stall", 32'(lsu_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", 32'(dmem_req), 32'd0);
    chk("rst_stall_drop", 32'(lsu_stall), 32'd0);
    chk("rst_wb_data_clear", wb_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b0; exp_exc = 1'b0; exp_berr = 1'b0;
    exp_rd = 5'd0; exp_data = 32'h0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h55AA_55AA;
    step();
    dmem_ack = 1'b0;
    step();
    step();
    step();
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
